// File: rtl/pipe_stage_reg_pkg.sv
// Shared constants for the pipeline stage register: reset/stall polarities,
// mode selectors, skid-buffer state encodings and main-entry load selects.
package pipe_stage_reg_pkg;

    localparam logic RstEnable = 1'b0;
    localparam logic Stop      = 1'b1;
    localparam logic NoStop    = 1'b0;

    localparam int MODE_STALL = 0;
    localparam int MODE_SKID  = 1;

    // State encodings double as the occupancy count.
    localparam logic [1:0] ST_EMPTY = 2'b00;
    localparam logic [1:0] ST_ONE   = 2'b01;
    localparam logic [1:0] ST_TWO   = 2'b10;

    localparam logic [1:0] SEL_HOLD   = 2'b00;
    localparam logic [1:0] SEL_IN     = 2'b01;
    localparam logic [1:0] SEL_SKID   = 2'b10;
    localparam logic [1:0] SEL_BUBBLE = 2'b11;

endpackage

// File: rtl/pipe_skid_ctrl.sv
// Occupancy FSM for the two-entry skid buffer; drives the registered in_ready
// and tells the datapath how to load the main and skid entries.
module pipe_skid_ctrl
    import pipe_stage_reg_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       flush,
    input  logic       in_valid,
    input  logic       out_ready,
    output logic       in_ready,
    output logic       out_valid,
    output logic [1:0] occupancy,
    output logic [1:0] main_sel,
    output logic       skid_load
);

    logic [1:0] state;
    logic [1:0] state_next;
    logic       ready_reg;
    logic       push;
    logic       pop;

    assign push      = in_valid & ready_reg;
    assign pop       = out_valid & out_ready;
    assign out_valid = (state != ST_EMPTY);
    assign occupancy = state;
    assign in_ready  = ready_reg;

    always_comb begin
        state_next = state;
        main_sel   = SEL_HOLD;
        skid_load  = 1'b0;
        case (state)
            ST_EMPTY: begin
                if (push) begin
                    state_next = ST_ONE;
                    main_sel   = SEL_IN;
                end
            end
            ST_ONE: begin
                if (push && !pop) begin
                    state_next = ST_TWO;
                    skid_load  = 1'b1;
                end else if (pop && !push) begin
                    state_next = ST_EMPTY;
                    main_sel   = SEL_BUBBLE;
                end else if (push && pop) begin
                    main_sel   = SEL_IN;
                end
            end
            ST_TWO: begin
                if (pop) begin
                    state_next = ST_ONE;
                    main_sel   = SEL_SKID;
                end
            end
            default: begin
                state_next = ST_EMPTY;
                main_sel   = SEL_BUBBLE;
            end
        endcase
        // Squash overrides everything; a pop this cycle has already been seen downstream.
        if (flush) begin
            state_next = ST_EMPTY;
            main_sel   = SEL_BUBBLE;
            skid_load  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            state     <= ST_EMPTY;
            ready_reg <= 1'b0;
        end else begin
            state     <= state_next;
            ready_reg <= (state_next != ST_TWO);
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register: either a stall-vector controlled register (MODE 0)
// or a valid/ready two-entry skid buffer (MODE 1).
module pipe_stage_reg
    import pipe_stage_reg_pkg::*;
#(
    parameter int               WIDTH   = 64,
    parameter int               STAGE   = 3,
    parameter int               STALL_W = 6,
    parameter int               MODE    = 0,
    parameter logic [WIDTH-1:0] BUBBLE  = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [STALL_W-1:0] stall,
    input  logic               flush,
    input  logic               in_valid,
    input  logic [WIDTH-1:0]   in_data,
    output logic               in_ready,
    output logic               out_valid,
    output logic [WIDTH-1:0]   out_data,
    input  logic               out_ready,
    output logic [1:0]         occupancy
);

    if (MODE == MODE_STALL) begin : g_stall
        logic             stall_here;
        logic             stall_next;
        logic             ready_en;
        logic             valid_p0;
        logic [WIDTH-1:0] data_p0;
        logic             unused_inputs;

        assign stall_here = stall[STAGE];

        // The last stage has no downstream stall bit; treat it as running.
        if (STAGE == STALL_W - 1) begin : g_last
            assign stall_next = NoStop;
        end else begin : g_mid
            assign stall_next = stall[STAGE+1];
        end

        // Stage p0: capture / bubble / hold register
        always_ff @(posedge clk) begin
            if (rst == RstEnable) begin
                ready_en <= 1'b0;
                valid_p0 <= 1'b0;
                data_p0  <= BUBBLE;
            end else begin
                ready_en <= 1'b1;
                if (flush) begin
                    valid_p0 <= 1'b0;
                    data_p0  <= BUBBLE;
                end else if (stall_here == Stop && stall_next == NoStop) begin
                    valid_p0 <= 1'b0;
                    data_p0  <= BUBBLE;
                end else if (stall_here == NoStop) begin
                    valid_p0 <= in_valid;
                    data_p0  <= in_data;
                end
            end
        end

        assign in_ready      = ready_en & ~stall_here;
        assign out_valid     = valid_p0;
        assign out_data      = data_p0;
        assign occupancy     = {1'b0, valid_p0};
        assign unused_inputs = out_ready ^ (^stall);
    end else begin : g_skid
        logic [1:0]       main_sel;
        logic             skid_load;
        logic [WIDTH-1:0] main_p0;
        logic [WIDTH-1:0] skid_p0;
        logic             unused_inputs;

        pipe_skid_ctrl u_ctrl (
            .clk       (clk),
            .rst       (rst),
            .flush     (flush),
            .in_valid  (in_valid),
            .out_ready (out_ready),
            .in_ready  (in_ready),
            .out_valid (out_valid),
            .occupancy (occupancy),
            .main_sel  (main_sel),
            .skid_load (skid_load)
        );

        // Stage p0: main entry (visible) and skid entry (overflow)
        always_ff @(posedge clk) begin
            if (rst == RstEnable) begin
                main_p0 <= BUBBLE;
            end else begin
                case (main_sel)
                    SEL_IN:     main_p0 <= in_data;
                    SEL_SKID:   main_p0 <= skid_p0;
                    SEL_BUBBLE: main_p0 <= BUBBLE;
                    default:    main_p0 <= main_p0;
                endcase
            end
        end

        always_ff @(posedge clk) begin
            if (skid_load) begin
                skid_p0 <= in_data;
            end
        end

        assign out_data      = main_p0;
        assign unused_inputs = ^stall;
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: stall-mode vector table plus a queue-modelled
// skid buffer exercised with directed and random traffic.
module tb_pipe_stage_reg;

    localparam logic [7:0] BUB0 = 8'hEE;
    localparam logic [7:0] BUB1 = 8'hBB;

    logic       clk;
    logic       rst;

    logic [5:0] s0_stall;
    logic       s0_flush, s0_iv, s0_ordy;
    logic [7:0] s0_id;
    logic       s0_rdy, s0_ov;
    logic [7:0] s0_od;
    logic [1:0] s0_occ;

    logic       last_rdy, last_ov;
    logic [7:0] last_od;
    logic [1:0] last_occ;

    logic [5:0] s1_stall;
    logic       s1_flush, s1_iv, s1_ordy;
    logic [7:0] s1_id;
    logic       s1_rdy, s1_ov;
    logic [7:0] s1_od;
    logic [1:0] s1_occ;

    int pass_cnt = 0;
    int total_cnt = 0;

    logic [7:0] q[$];
    logic       model_rdy;

    pipe_stage_reg #(.WIDTH(8), .STAGE(3), .STALL_W(6), .MODE(0), .BUBBLE(BUB0)) u_stall (
        .clk(clk), .rst(rst), .stall(s0_stall), .flush(s0_flush), .in_valid(s0_iv),
        .in_data(s0_id), .in_ready(s0_rdy), .out_valid(s0_ov), .out_data(s0_od),
        .out_ready(s0_ordy), .occupancy(s0_occ)
    );

    pipe_stage_reg #(.WIDTH(8), .STAGE(5), .STALL_W(6), .MODE(0), .BUBBLE(BUB0)) u_last (
        .clk(clk), .rst(rst), .stall(s0_stall), .flush(s0_flush), .in_valid(s0_iv),
        .in_data(s0_id), .in_ready(last_rdy), .out_valid(last_ov), .out_data(last_od),
        .out_ready(s0_ordy), .occupancy(last_occ)
    );

    pipe_stage_reg #(.WIDTH(8), .STAGE(3), .STALL_W(6), .MODE(1), .BUBBLE(BUB1)) u_skid (
        .clk(clk), .rst(rst), .stall(s1_stall), .flush(s1_flush), .in_valid(s1_iv),
        .in_data(s1_id), .in_ready(s1_rdy), .out_valid(s1_ov), .out_data(s1_od),
        .out_ready(s1_ordy), .occupancy(s1_occ)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // One skid-buffer cycle: compare DUT with the queue model, then advance both.
    task automatic skid_cycle(input logic r, input logic iv, input logic [7:0] id,
                              input logic ordy, input logic fl);
        logic       push;
        logic       pop;
        logic [7:0] exp_d;
        rst = r; s1_iv = iv; s1_id = id; s1_ordy = ordy; s1_flush = fl;
        s1_stall = 6'($urandom_range(0, 63));
        #1;
        chk("skid_in_ready", 32'(s1_rdy), 32'(model_rdy));
        chk("skid_out_valid", 32'(s1_ov), 32'(q.size() != 0));
        chk("skid_occupancy", 32'(s1_occ), 32'(q.size()));
        push = iv && model_rdy && r;
        pop  = ordy && (q.size() != 0) && r;
        if (pop) begin
            exp_d = q.pop_front();
            chk("skid_pop_data", 32'(s1_od), 32'(exp_d));
        end else if (q.size() == 0) begin
            chk("skid_empty_data", 32'(s1_od), 32'(BUB1));
        end else begin
            chk("skid_hold_data", 32'(s1_od), 32'(q[0]));
        end
        @(posedge clk); #1;
        if (!r) begin
            q.delete();
            model_rdy = 1'b0;
        end else if (fl) begin
            q.delete();
            model_rdy = 1'b1;
        end else begin
            if (push) q.push_back(id);
            model_rdy = (q.size() < 2);
        end
    endtask

    typedef struct {
        logic [5:0] stall;
        logic       flush;
        logic       iv;
        logic [7:0] id;
        logic       rdy;
        logic       ov;
        logic [7:0] od;
    } vec_t;

    vec_t vecs [14];

    initial begin
        vecs[0]  = '{6'b000000, 1'b0, 1'b1, 8'h11, 1'b1, 1'b1, 8'h11};
        vecs[1]  = '{6'b011000, 1'b0, 1'b1, 8'h22, 1'b0, 1'b1, 8'h11};
        vecs[2]  = '{6'b011000, 1'b0, 1'b1, 8'h33, 1'b0, 1'b1, 8'h11};
        vecs[3]  = '{6'b011000, 1'b0, 1'b0, 8'h44, 1'b0, 1'b1, 8'h11};
        vecs[4]  = '{6'b000000, 1'b0, 1'b1, 8'h55, 1'b1, 1'b1, 8'h55};
        vecs[5]  = '{6'b001000, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0, BUB0};
        vecs[6]  = '{6'b000000, 1'b0, 1'b0, 8'h66, 1'b1, 1'b0, 8'h66};
        vecs[7]  = '{6'b000000, 1'b0, 1'b1, 8'h77, 1'b1, 1'b1, 8'h77};
        vecs[8]  = '{6'b000000, 1'b1, 1'b1, 8'h88, 1'b1, 1'b0, BUB0};
        vecs[9]  = '{6'b000100, 1'b0, 1'b1, 8'h99, 1'b1, 1'b1, 8'h99};
        vecs[10] = '{6'b011000, 1'b1, 1'b1, 8'hAA, 1'b0, 1'b0, BUB0};
        vecs[11] = '{6'b010000, 1'b0, 1'b1, 8'hBB, 1'b1, 1'b1, 8'hBB};
        vecs[12] = '{6'b001000, 1'b1, 1'b0, 8'hCC, 1'b0, 1'b0, BUB0};
        vecs[13] = '{6'b111111, 1'b0, 1'b1, 8'hDD, 1'b0, 1'b0, BUB0};

        rst = 1'b0;
        s0_stall = '0; s0_flush = 0; s0_iv = 0; s0_id = '0; s0_ordy = 0;
        s1_stall = '0; s1_flush = 0; s1_iv = 0; s1_id = '0; s1_ordy = 0;
        q.delete();
        model_rdy = 1'b0;

        // Reset state of all instances.
        repeat (2) @(posedge clk);
        #1;
        chk("rst_s0_valid", 32'(s0_ov), 32'd0);
        chk("rst_s0_data", 32'(s0_od), 32'(BUB0));
        chk("rst_s0_occ", 32'(s0_occ), 32'd0);
        chk("rst_s0_ready", 32'(s0_rdy), 32'd0);
        chk("rst_last_ready", 32'(last_rdy), 32'd0);
        chk("rst_skid_valid", 32'(s1_ov), 32'd0);
        chk("rst_skid_data", 32'(s1_od), 32'(BUB1));
        chk("rst_skid_occ", 32'(s1_occ), 32'd0);
        chk("rst_skid_ready", 32'(s1_rdy), 32'd0);

        rst = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_s0_ready", 32'(s0_rdy), 32'd1);
        chk("post_rst_skid_ready", 32'(s1_rdy), 32'd1);
        model_rdy = 1'b1;

        // Stall-mode vector table.
        for (int i = 0; i < 14; i++) begin
            s0_stall = vecs[i].stall; s0_flush = vecs[i].flush;
            s0_iv = vecs[i].iv; s0_id = vecs[i].id; s0_ordy = 1'($urandom_range(0, 1));
            #1;
            chk($sformatf("vec%0d_in_ready", i), 32'(s0_rdy), 32'(vecs[i].rdy));
            @(posedge clk); #1;
            chk($sformatf("vec%0d_out_valid", i), 32'(s0_ov), 32'(vecs[i].ov));
            chk($sformatf("vec%0d_out_data", i), 32'(s0_od), 32'(vecs[i].od));
            chk($sformatf("vec%0d_occupancy", i), 32'({1'b0, vecs[i].ov}), 32'(s0_occ));
        end

        // Last stage: no stall bit above it, so a set stall bit bubbles.
        s0_stall = 6'b000000; s0_flush = 0; s0_iv = 1; s0_id = 8'h42;
        #1;
        chk("last_ready_run", 32'(last_rdy), 32'd1);
        @(posedge clk); #1;
        chk("last_capture_valid", 32'(last_ov), 32'd1);
        chk("last_capture_data", 32'(last_od), 32'h42);
        s0_stall = 6'b100000; s0_id = 8'h43;
        #1;
        chk("last_ready_stall", 32'(last_rdy), 32'd0);
        @(posedge clk); #1;
        chk("last_bubble_valid", 32'(last_ov), 32'd0);
        chk("last_bubble_data", 32'(last_od), 32'(BUB0));
        chk("last_bubble_occ", 32'(last_occ), 32'd0);

        // Skid buffer: fill to two with downstream blocked, then drain in order.
        skid_cycle(1, 1, 8'h01, 0, 0);
        skid_cycle(1, 1, 8'h02, 0, 0);
        skid_cycle(1, 1, 8'h03, 0, 0);
        skid_cycle(1, 1, 8'h03, 0, 0);
        skid_cycle(1, 1, 8'h03, 1, 0);
        skid_cycle(1, 0, 8'h00, 1, 0);
        // Simultaneous push and pop at occupancy one.
        skid_cycle(1, 1, 8'h05, 0, 0);
        skid_cycle(1, 1, 8'h07, 1, 0);
        skid_cycle(1, 0, 8'h00, 0, 0);
        // Flush at occupancy two and at one with a live push and pop.
        skid_cycle(1, 1, 8'h08, 0, 0);
        skid_cycle(1, 1, 8'h09, 0, 1);
        skid_cycle(1, 0, 8'h00, 0, 0);
        skid_cycle(1, 1, 8'h0A, 0, 0);
        skid_cycle(1, 1, 8'h0B, 1, 1);
        skid_cycle(1, 0, 8'h00, 0, 0);
        // Random traffic.
        for (int i = 0; i < 80; i++) begin
            skid_cycle(1, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
                       1'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0));
        end
        // Reset with two entries held.
        skid_cycle(1, 0, 8'h00, 0, 1);
        skid_cycle(1, 1, 8'hC1, 0, 0);
        skid_cycle(1, 1, 8'hC2, 0, 0);
        chk("pre_rst_occ_two", 32'(s1_occ), 32'd2);
        s0_stall = 6'b000000; s0_iv = 1; s0_id = 8'h5A;
        skid_cycle(0, 1, 8'hC3, 0, 0);
        chk("midrst_s0_valid", 32'(s0_ov), 32'd0);
        chk("midrst_s0_data", 32'(s0_od), 32'(BUB0));
        chk("midrst_s0_ready", 32'(s0_rdy), 32'd0);
        skid_cycle(1, 0, 8'h00, 0, 0);
        chk("after_rst_s0_ready", 32'(s0_rdy), 32'd1);
        skid_cycle(1, 1, 8'hD1, 1, 0);
        skid_cycle(1, 0, 8'h00, 1, 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
